// File: rtl/bus_simple_pkg.sv
// Shared types for the simple 32-bit bus decoder: FSM states, error read data
// and the latched request bundle.
package bus_simple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2
  } bus_dec_state_e;

  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_simple_decoder.sv
// Slave-side address decoder / response router for the simple 32-bit bus.
// Optional slave-response timeout is built when BUS_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | accepting a new request from the master
// ST_FWD  | slave request issued, waiting for that slave's reply
// ST_ERR  | error response (unmapped or timed out) pending
module bus_simple_decoder
  import bus_simple_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SEL_LSB     = 16,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_valid,
  input  logic                     m_write,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic                     m_rvalid,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_write,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES-1:0]    s_rvalid,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     err_pulse
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536)
  begin : g_param_check
    $error("bus_simple_decoder: parameter out of range");
  end

  bus_dec_state_e        state;
  bus_req_t              req;
  logic [SEL_W-1:0]      sel;
  logic [NUM_SLAVES-1:0] sel_mask;

  logic [SEL_W-1:0]      addr_sel;
  logic                  addr_mapped;
  logic [NUM_SLAVES-1:0] addr_mask;
  logic                  resp_hit;
  logic [31:0]           slave_rdata;
  logic                  timeout_hit;

  assign addr_sel    = m_addr[SEL_LSB +: SEL_W];
  assign addr_mapped = 32'(addr_sel) < NUM_SLAVES;
  assign addr_mask   = NUM_SLAVES'(1) << addr_sel;

  // Only the latched slave's response of the matching type counts.
  assign resp_hit    = req.write ? |(s_ready & sel_mask) : |(s_rvalid & sel_mask);
  assign slave_rdata = s_rdata[32'(sel)*32 +: 32];

  assign s_write = req.write;
  assign s_addr  = req.addr;
  assign s_wdata = req.wdata;
  assign s_wstrb = req.wstrb;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 256) ? 16 : 8;
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE && m_valid && addr_mapped) begin
      to_cnt <= '0;
    end else if (state == ST_FWD) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req       <= '0;
      sel       <= '0;
      sel_mask  <= '0;
      s_valid   <= '0;
      m_ready   <= 1'b0;
      m_rvalid  <= 1'b0;
      m_rdata   <= '0;
      err_pulse <= 1'b0;
    end else begin
      s_valid   <= '0;
      m_ready   <= 1'b0;
      m_rvalid  <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            req      <= '{write: m_write, addr: m_addr, wdata: m_wdata, wstrb: m_wstrb};
            sel      <= addr_sel;
            sel_mask <= addr_mask;
            if (addr_mapped) begin
              s_valid <= addr_mask;
              state   <= ST_FWD;
            end else begin
              state   <= ST_ERR;
            end
          end
        end
        ST_FWD: begin
          // A response landing on the expiry cycle still wins over the timeout.
          if (resp_hit) begin
            if (req.write) begin
              m_ready  <= 1'b1;
            end else begin
              m_rvalid <= 1'b1;
              m_rdata  <= slave_rdata;
            end
            state <= ST_IDLE;
          end else if (timeout_hit) begin
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          if (req.write) begin
            m_ready  <= 1'b1;
          end else begin
            m_rvalid <= 1'b1;
            m_rdata  <= BUS_ERR_RDATA;
          end
          err_pulse <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_simple_decoder.sv
// Scoreboard bench for bus_simple_decoder: directed cases plus randomized traffic.
// Timeout cases run only when BUS_TIMEOUT_EN is defined.
module tb_bus_simple_decoder;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_valid = 1'b0, m_write = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0] m_wstrb = '0;
  logic m_ready, m_rvalid, err_pulse;
  logic [31:0] m_rdata;
  logic [NS-1:0] s_valid;
  logic s_write;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic [NS-1:0] s_ready = '0, s_rvalid = '0;
  logic [NS*32-1:0] s_rdata = '0;

  bus_simple_decoder #(.NUM_SLAVES(NS), .SEL_LSB(16), .SEL_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
  } sreq_t;

  typedef struct {
    bit          write;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } mresp_t;

  sreq_t  sq[$];
  mresp_t rq[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: waits lat cycles (raising decoy responses meanwhile), then answers.
  task automatic respond(input sreq_t e);
    int k = int'(e.addr[19:16]);
    for (int i = 0; i < e.lat; i++) begin
      if (i % 2 == 0) begin
        s_rvalid[(k + 1) % NS] = 1'b1;
        s_ready[(k + 1) % NS]  = 1'b1;
      end else if (e.write) begin
        s_rvalid[k] = 1'b1;
      end else begin
        s_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      s_ready = '0; s_rvalid = '0;
    end
    for (int j = 0; j < NS; j++) s_rdata[j*32 +: 32] = $urandom;
    s_rdata[k*32 +: 32] = e.rdata;
    if (e.write) s_ready[k] = 1'b1; else s_rvalid[k] = 1'b1;
    @(posedge clk); #1;
    s_ready = '0; s_rvalid = '0;
  endtask

  // Request-side monitor: every s_valid must match an accepted mapped request.
  sreq_t cur;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (s_valid != '0) begin
        check(sq.size() != 0, "unexpected_s_valid", s_valid, 0);
        if (sq.size() != 0) begin
          cur = sq.pop_front();
          check(s_valid == (NS'(1) << cur.addr[19:16]), "s_valid", s_valid, NS'(1) << cur.addr[19:16]);
          check(s_addr == cur.addr, "s_addr", s_addr, cur.addr);
          check({s_write, s_wstrb, s_wdata} == {cur.write, cur.wstrb, cur.wdata}, "s_fields",
                {s_write, s_wstrb, s_wdata}, {cur.write, cur.wstrb, cur.wdata});
          fork
            respond(cur);
          join_none
        end
      end
    end
  end

  // Response-side monitor: pops the scoreboard on every master response pulse.
  mresp_t got;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_ready || m_rvalid) begin
        check(rq.size() != 0, "unexpected_response", {m_ready, m_rvalid}, 0);
        if (rq.size() != 0) begin
          got = rq.pop_front();
          check({m_ready, m_rvalid} == {got.write, !got.write}, "resp_kind", {m_ready, m_rvalid}, {got.write, !got.write});
          check(cyc == got.cyc, "resp_cycle", cyc, got.cyc);
          check(err_pulse == got.err, "err_pulse", err_pulse, got.err);
          if (!got.write) last_rdata = got.rdata;
          check(m_rdata == last_rdata, "m_rdata", m_rdata, last_rdata);
        end
      end else begin
        check(!err_pulse, "stray_err_pulse", err_pulse, 0);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // mode 0: normal response expected, 1: none expected, 2: timeout error expected
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int lat, input logic [31:0] rdata, input int mode);
    bit mapped = (addr[19:16] < NS);
    int t = cyc + 1;
    if (mapped) sq.push_back('{wr, addr, wdata, strb, lat, rdata});
    if (mode == 0)
      rq.push_back('{wr, !mapped, mapped ? rdata : ERR_WORD, mapped ? t + lat + 1 : t + 1});
    else if (mode == 2)
      rq.push_back('{wr, 1'b1, ERR_WORD, t + TO + 1});
    m_valid = 1'b1; m_write = wr; m_addr = addr; m_wdata = wdata; m_wstrb = strb;
    @(posedge clk); #2;
    m_valid = 1'b0; m_write = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
  endtask

  task automatic raw_request(input logic [31:0] addr);
    m_valid = 1'b1; m_write = 1'($urandom); m_addr = addr; m_wdata = $urandom; m_wstrb = 4'hF;
    @(posedge clk); #2;
    m_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && rq.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    check(rq.size() == 0, "response_wait", rq.size(), 0);
    rq.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({m_ready, m_rvalid, err_pulse, s_valid} == '0, {name, "_pulses"}, {m_ready, m_rvalid, err_pulse, s_valid}, 0);
    check(m_rdata == 32'h0, {name, "_m_rdata"}, m_rdata, 0);
    check({s_write, s_addr, s_wdata, s_wstrb} == '0, {name, "_s_fields"}, s_addr, 0);
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk); #2;
    check_all_zero("reset");
    rst = 1'b0;

    issue(1'b1, 32'h0001_0010, 32'h1234_5678, 4'hF, 1, 32'h0, 0);
    wait_done(20);
    issue(1'b0, 32'h0002_0004, 32'h0, 4'h0, 4, 32'hCAFE_0002, 0);
    wait_done(20);
    issue(1'b0, 32'h0007_0000, 32'h0, 4'h0, 0, 32'h0, 0);
    wait_done(20);
    issue(1'b1, 32'h0003_00F0, 32'hA5A5_0000, 4'h3, 0, 32'h0, 0);
    wait_done(20);

    // Requests arriving while busy (FWD, then ERR) must vanish.
    issue(1'b0, 32'h0001_0020, 32'h0, 4'h0, 4, 32'h1111_2222, 0);
    raw_request(32'h0002_0000);
    wait_done(20);
    issue(1'b1, 32'h000F_0000, 32'h0, 4'hF, 0, 32'h0, 0);
    raw_request(32'h0001_0000);
    wait_done(20);
    repeat (3) @(posedge clk); #2;

    // Reset while in FWD; the slave's late answer must be ignored.
    issue(1'b0, 32'h0001_0008, 32'h0, 4'h0, 20, 32'h7777_7777, 1);
    repeat (2) @(posedge clk); #2;
    rst = 1'b1;
    last_rdata = '0;
    @(posedge clk); #2;
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (25) @(posedge clk); #2;
    issue(1'b0, 32'h0001_0100, 32'h0, 4'h0, 2, 32'h5A5A_1111, 0);
    wait_done(20);

`ifdef BUS_TIMEOUT_EN
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 12, 32'h9999_0000, 2);
    wait_done(30);
    repeat (8) @(posedge clk); #2;
    issue(1'b0, 32'h0000_0044, 32'h0, 4'h0, TO - 1, 32'h4444_0007, 0);
    wait_done(30);
    issue(1'b1, 32'h0003_0000, 32'h0BAD_F00D, 4'hF, 20, 32'h0, 2);
    wait_done(30);
    repeat (16) @(posedge clk); #2;
`endif

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[19:16] = 4'($urandom_range(0, 7));
      issue(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 5), $urandom, 0);
      wait_done(20);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
      end
    end

    repeat (30) @(posedge clk); #2;
    check(rq.size() == 0 && sq.size() == 0, "queues_drained", rq.size() + sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
